// File: rtl/l1_stack_distance_tracker.sv
// ---------------------------------------------------------------------------
// l1_stack_distance_tracker
//
// Purpose:
//   Feeds the L2 subset-simulation stage. Each byte-address trace request is
//   looked up in a per-set true-LRU tag stack (WAY deep, 2*SET_SIZE sets).
//   The access's stack distance is reported downstream as {msb_index, hit_way}
//   using a find_start / updated handshake. Hit and miss counters saturate
//   at 20'hFFFFF.
//
// Ports:
//   clk            clock
//   reset          synchronous, active-high reset
//   addr_valid     trace request valid
//   addr           trace byte address
//   addr_ready     block is idle and will accept a request
//   find_start     one-cycle pulse: msb_index/hit_way are valid
//   msb_index      set index addr[OFF+SET_INDEX:OFF]
//   hit_way        stack distance 0..WAY-1 on hit, WAY on miss
//   updated        downstream done pulse (only honoured while waiting)
//   l1_hit_count   saturating hit counter
//   l1_miss_count  saturating miss counter
//   busy           block is not idle
//
// Build option:
//   L1_PARALLEL_SEARCH_EN  when defined, the whole stack is compared in a
//                          single SEARCH cycle (priority encoder, lowest
//                          matching position wins). Results are identical;
//                          only the latency changes.
// ---------------------------------------------------------------------------
module l1_stack_distance_tracker #(
   parameter int ADDR_WIDTH      = 32,
   parameter int WAY             = 16,
   parameter int BLOCK_SIZE_BYTE = 16,
   parameter int SET_SIZE        = 512,
   parameter int WAY_WIDTH       = $clog2(WAY)
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          addr_valid,
   input  logic [ADDR_WIDTH-1:0]         addr,
   output logic                          addr_ready,
   output logic                          find_start,
   output logic [$clog2(SET_SIZE):0]     msb_index,
   output logic [WAY_WIDTH:0]            hit_way,
   input  logic                          updated,
   output logic [19:0]                   l1_hit_count,
   output logic [19:0]                   l1_miss_count,
   output logic                          busy
);

   localparam int OFF       = $clog2(BLOCK_SIZE_BYTE);
   localparam int SET_INDEX = $clog2(SET_SIZE);
   localparam int SETS      = 2 * SET_SIZE;
   localparam int TAG_W     = ADDR_WIDTH - OFF - SET_INDEX - 1;

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_SEARCH = 3'd1,
      S_UPDATE = 3'd2,
      S_ISSUE  = 3'd3,
      S_WAIT   = 3'd4
   } state_t;

   state_t                  state_q, state_d;
   logic [TAG_W-1:0]        tag_q, tag_d;
   logic [SET_INDEX:0]      idx_q, idx_d;
   logic [WAY_WIDTH-1:0]    dist_q, dist_d;
   logic                    hit_q, hit_d;
   logic                    addr_ready_q, addr_ready_d;
   logic                    find_start_q, find_start_d;
   logic                    busy_q, busy_d;
   logic [SET_INDEX:0]      msb_index_q, msb_index_d;
   logic [WAY_WIDTH:0]      hit_way_q, hit_way_d;
   logic [19:0]             hit_cnt_q, hit_cnt_d;
   logic [19:0]             miss_cnt_q, miss_cnt_d;

   // Stack storage: entry 0 of each row is MRU, valid bits stay contiguous.
   logic [SETS-1:0][WAY-1:0]        valid_q;
   logic [WAY-1:0][TAG_W-1:0]       stack_tag_q [SETS];

   logic [WAY-1:0]                  row_valid_s, row_valid_d;
   logic [WAY-1:0][TAG_W-1:0]       row_tag_s, row_tag_d;

   logic                    resolve_s;
   logic                    found_s;
   logic [WAY_WIDTH-1:0]    pos_s;

   // The block offset never takes part in the lookup.
   logic                    unused_offset_s;
   assign unused_offset_s = ^addr[OFF-1:0];

   assign row_valid_s = valid_q[idx_q];
   assign row_tag_s   = stack_tag_q[idx_q];

`ifdef L1_PARALLEL_SEARCH_EN
   // Whole-row compare; scanning downward leaves the lowest match in pos_s.
   always_comb begin
      resolve_s = 1'b1;
      found_s   = 1'b0;
      pos_s     = {WAY_WIDTH{1'b0}};
      for (int i = WAY - 1; i >= 0; i--) begin
         if (row_valid_s[i] && (row_tag_s[i] == tag_q)) begin
            found_s = 1'b1;
            pos_s   = WAY_WIDTH'(i);
         end else begin
            found_s = found_s;
         end
      end
   end
`else
   logic [WAY_WIDTH-1:0]    ptr_q, ptr_d;

   // One entry per cycle; an invalid entry ends the (contiguous) stack.
   always_comb begin
      resolve_s = 1'b0;
      found_s   = 1'b0;
      pos_s     = ptr_q;
      if (!row_valid_s[ptr_q]) begin
         resolve_s = 1'b1;
      end else if (row_tag_s[ptr_q] == tag_q) begin
         resolve_s = 1'b1;
         found_s   = 1'b1;
      end else if (ptr_q == WAY_WIDTH'(WAY - 1)) begin
         resolve_s = 1'b1;
      end else begin
         resolve_s = 1'b0;
      end
   end
`endif

   // New row contents: hit shifts entries 0..d-1 down, miss shifts everything.
   always_comb begin
      row_tag_d    = row_tag_s;
      row_tag_d[0] = tag_q;
      for (int i = 1; i < WAY; i++) begin
         if (!hit_q || (WAY_WIDTH'(i) <= dist_q)) begin
            row_tag_d[i] = row_tag_s[i-1];
         end else begin
            row_tag_d[i] = row_tag_s[i];
         end
      end
      if (hit_q) begin
         row_valid_d = row_valid_s;
      end else begin
         row_valid_d = {row_valid_s[WAY-2:0], 1'b1};
      end
   end

   // Next-state and registered-output logic for the request FSM.
   always_comb begin
      state_d      = state_q;
      tag_d        = tag_q;
      idx_d        = idx_q;
      dist_d       = dist_q;
      hit_d        = hit_q;
      addr_ready_d = addr_ready_q;
      find_start_d = find_start_q;
      busy_d       = busy_q;
      msb_index_d  = msb_index_q;
      hit_way_d    = hit_way_q;
      hit_cnt_d    = hit_cnt_q;
      miss_cnt_d   = miss_cnt_q;
`ifndef L1_PARALLEL_SEARCH_EN
      ptr_d        = ptr_q;
`endif
      case (state_q)
         S_IDLE: begin
            if (addr_valid) begin
               tag_d        = addr[ADDR_WIDTH-1:OFF+SET_INDEX+1];
               idx_d        = addr[OFF+SET_INDEX:OFF];
`ifndef L1_PARALLEL_SEARCH_EN
               ptr_d        = {WAY_WIDTH{1'b0}};
`endif
               addr_ready_d = 1'b0;
               busy_d       = 1'b1;
               state_d      = S_SEARCH;
            end else begin
               addr_ready_d = 1'b1;
               busy_d       = 1'b0;
            end
         end
         S_SEARCH: begin
            if (resolve_s) begin
               hit_d   = found_s;
               dist_d  = pos_s;
               state_d = S_UPDATE;
            end else begin
`ifndef L1_PARALLEL_SEARCH_EN
               ptr_d   = ptr_q + WAY_WIDTH'(1);
`endif
               state_d = S_SEARCH;
            end
         end
         S_UPDATE: begin
            if (hit_q) begin
               if (hit_cnt_q != 20'hFFFFF) begin
                  hit_cnt_d = hit_cnt_q + 20'd1;
               end else begin
                  hit_cnt_d = hit_cnt_q;
               end
               hit_way_d = {1'b0, dist_q};
            end else begin
               if (miss_cnt_q != 20'hFFFFF) begin
                  miss_cnt_d = miss_cnt_q + 20'd1;
               end else begin
                  miss_cnt_d = miss_cnt_q;
               end
               hit_way_d = (WAY_WIDTH+1)'(WAY);
            end
            msb_index_d  = idx_q;
            find_start_d = 1'b1;
            state_d      = S_ISSUE;
         end
         S_ISSUE: begin
            find_start_d = 1'b0;
            state_d      = S_WAIT;
         end
         S_WAIT: begin
            if (updated) begin
               addr_ready_d = 1'b1;
               busy_d       = 1'b0;
               state_d      = S_IDLE;
            end else begin
               state_d      = S_WAIT;
            end
         end
         default: begin
            find_start_d = 1'b0;
            addr_ready_d = 1'b1;
            busy_d       = 1'b0;
            state_d      = S_IDLE;
         end
      endcase
   end

   // Control and output registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= S_IDLE;
         tag_q        <= {TAG_W{1'b0}};
         idx_q        <= {(SET_INDEX+1){1'b0}};
         dist_q       <= {WAY_WIDTH{1'b0}};
         hit_q        <= 1'b0;
         addr_ready_q <= 1'b1;
         find_start_q <= 1'b0;
         busy_q       <= 1'b0;
         msb_index_q  <= {(SET_INDEX+1){1'b0}};
         hit_way_q    <= {(WAY_WIDTH+1){1'b0}};
         hit_cnt_q    <= 20'd0;
         miss_cnt_q   <= 20'd0;
`ifndef L1_PARALLEL_SEARCH_EN
         ptr_q        <= {WAY_WIDTH{1'b0}};
`endif
      end else begin
         state_q      <= state_d;
         tag_q        <= tag_d;
         idx_q        <= idx_d;
         dist_q       <= dist_d;
         hit_q        <= hit_d;
         addr_ready_q <= addr_ready_d;
         find_start_q <= find_start_d;
         busy_q       <= busy_d;
         msb_index_q  <= msb_index_d;
         hit_way_q    <= hit_way_d;
         hit_cnt_q    <= hit_cnt_d;
         miss_cnt_q   <= miss_cnt_d;
`ifndef L1_PARALLEL_SEARCH_EN
         ptr_q        <= ptr_d;
`endif
      end
   end

   // Valid bits: cleared on reset, row rewritten in UPDATE.
   always_ff @(posedge clk) begin
      if (reset) begin
         valid_q <= {(SETS*WAY){1'b0}};
      end else if (state_q == S_UPDATE) begin
         valid_q[idx_q] <= row_valid_d;
      end else begin
         valid_q <= valid_q;
      end
   end

   // Tag rows need no reset; the valid bits qualify them.
   always_ff @(posedge clk) begin
      if (!reset && (state_q == S_UPDATE)) begin
         stack_tag_q[idx_q] <= row_tag_d;
      end
   end

   assign addr_ready    = addr_ready_q;
   assign find_start    = find_start_q;
   assign busy          = busy_q;
   assign msb_index     = msb_index_q;
   assign hit_way       = hit_way_q;
   assign l1_hit_count  = hit_cnt_q;
   assign l1_miss_count = miss_cnt_q;

endmodule

// File: tb/tb_l1_stack_distance_tracker.sv
// ---------------------------------------------------------------------------
// tb_l1_stack_distance_tracker
//
// Directed bench for l1_stack_distance_tracker. A queue-per-set LRU model
// predicts every access; a negedge compare process checks the handshake,
// outputs and counters each cycle, and literal expectations pin the model.
// ---------------------------------------------------------------------------
module tb_l1_stack_distance_tracker;

`ifdef L1_PARALLEL_SEARCH_EN
   localparam bit PAR = 1'b1;
`else
   localparam bit PAR = 1'b0;
`endif
   localparam int BIG = 32'h3FFFFFFF;

   logic        clk = 1'b0;
   logic        reset;
   logic        addr_valid;
   logic [31:0] addr;
   logic        addr_ready;
   logic        find_start;
   logic [9:0]  msb_index;
   logic [4:0]  hit_way;
   logic        updated;
   logic [19:0] l1_hit_count;
   logic [19:0] l1_miss_count;
   logic        busy;

   l1_stack_distance_tracker dut (
      .clk           (clk),
      .reset         (reset),
      .addr_valid    (addr_valid),
      .addr          (addr),
      .addr_ready    (addr_ready),
      .find_start    (find_start),
      .msb_index     (msb_index),
      .hit_way       (hit_way),
      .updated       (updated),
      .l1_hit_count  (l1_hit_count),
      .l1_miss_count (l1_miss_count),
      .busy          (busy)
   );

   always #5 clk = ~clk;

   int edges = 0;
   always @(posedge clk) edges <= edges + 1;

   int tests = 0;
   int fails = 0;

   // reference LRU stacks, MRU at index 0
   int unsigned stk [1024][$];

   // current transaction expectations
   int acc_edge = 0;
   int fs_edge  = -1;
   int rel_edge = 0;
   int exp_idx  = 0;
   int exp_way  = 0;
   bit have_out = 1'b0;
   bit cur_hit  = 1'b0;
   bit cur_miss = 1'b0;
   int m_hits   = 0;
   int m_misses = 0;
   int obs_fs   = -1;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h, expected %0h (edge %0d)", nm, act, exp, edges);
      end
   endtask

   task automatic model_access(input logic [31:0] a, output bit h, output int p, output int l);
      int          idx;
      int unsigned tg;
      idx = int'((a >> 4) & 32'h3FF);
      tg  = a >> 14;
      p   = -1;
      for (int j = 0; j < stk[idx].size(); j++) begin
         if (p < 0 && stk[idx][j] == tg) p = j;
      end
      h = (p >= 0);
      if (h) begin
         l = p;
         stk[idx].delete(p);
      end else begin
         l = (stk[idx].size() < 16) ? stk[idx].size() : 15;
         p = 16;
      end
      stk[idx].push_front(tg);
      if (stk[idx].size() > 16) void'(stk[idx].pop_back());
      if (PAR) l = 0;
   endtask

   // Called at a negedge with the DUT idle (or becoming idle at the next edge).
   task automatic start_txn(input logic [31:0] a, input bit keep);
      bit h;
      int p;
      int l;
      model_access(a, h, p, l);
      addr       = a;
      addr_valid = 1'b1;
      acc_edge   = edges + 1;
      fs_edge    = acc_edge + 2 + l;
      rel_edge   = BIG;
      exp_idx    = int'((a >> 4) & 32'h3FF);
      exp_way    = p;
      cur_hit    = h;
      cur_miss   = !h;
      have_out   = 1'b1;
      if (h) m_hits++; else m_misses++;
      @(negedge clk);
      if (!keep) addr_valid = 1'b0;
   endtask

   task automatic finish_txn(input int waitc);
      int k;
      k      = 0;
      obs_fs = -1;
      while (k < 40 && obs_fs < 0) begin
         if (find_start === 1'b1) obs_fs = edges;
         else begin
            @(negedge clk);
            k++;
         end
      end
      if (obs_fs < 0) chk("find_start_timeout", 32'd0, 32'd1);
      @(negedge clk);
      repeat (waitc) @(negedge clk);
      updated  = 1'b1;
      rel_edge = edges + 1;
      @(negedge clk);
      updated  = 1'b0;
   endtask

   task automatic access(input logic [31:0] a);
      start_txn(a, 1'b0);
      finish_txn(0);
   endtask

   // Called at a negedge; returns at a negedge with reset released.
   task automatic apply_reset(input int n);
      reset      = 1'b1;
      addr_valid = 1'b0;
      updated    = 1'b0;
      acc_edge   = 0;
      rel_edge   = 0;
      fs_edge    = -1;
      have_out   = 1'b0;
      cur_hit    = 1'b0;
      cur_miss   = 1'b0;
      m_hits     = 0;
      m_misses   = 0;
      for (int i = 0; i < 1024; i++) stk[i].delete();
      repeat (n) @(negedge clk);
      reset = 1'b0;
   endtask

   // Per-cycle compare against the model-derived expectations.
   always @(negedge clk) begin
      bit eb;
      int eh;
      int em;
      #1;
      if (!reset) begin
         eb = (edges >= acc_edge) && (edges < rel_edge);
         chk("addr_ready", 32'(addr_ready), 32'(!eb));
         chk("busy", 32'(busy), 32'(eb));
         chk("find_start", 32'(find_start), 32'(edges == fs_edge));
         if (have_out && edges >= fs_edge) begin
            chk("msb_index", 32'(msb_index), 32'(exp_idx));
            chk("hit_way", 32'(hit_way), 32'(exp_way));
         end
         eh = m_hits - ((cur_hit && edges < fs_edge) ? 1 : 0);
         em = m_misses - ((cur_miss && edges < fs_edge) ? 1 : 0);
         chk("l1_hit_count", 32'(l1_hit_count), 32'(eh));
         chk("l1_miss_count", 32'(l1_miss_count), 32'(em));
      end
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not finish, expected completion");
      $fatal(1, "timeout");
   end

   initial begin
      addr = 32'd0;
      @(negedge clk);
      apply_reset(3);

      // reset state
      chk("rst_addr_ready", 32'(addr_ready), 32'd1);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_msb_index", 32'(msb_index), 32'd0);
      chk("rst_hit_way", 32'(hit_way), 32'd0);
      chk("rst_miss_count", 32'(l1_miss_count), 32'd0);

      // 1: cold miss
      access(32'h0000_0000);
      chk("t1_hit_way", 32'(hit_way), 32'd16);
      chk("t1_msb_index", 32'(msb_index), 32'd0);
      chk("t1_latency", 32'(obs_fs - acc_edge), 32'd2);
      chk("t1_miss_count", 32'(l1_miss_count), 32'd1);

      // 2: same block, different offset
      access(32'h0000_0008);
      chk("t2_hit_way", 32'(hit_way), 32'd0);
      chk("t2_latency", 32'(obs_fs - acc_edge), 32'd2);
      chk("t2_hit_count", 32'(l1_hit_count), 32'd1);

      // 3: recency order
      access(32'h0000_4000);
      access(32'h0000_8000);
      access(32'h0000_C000);
      access(32'h0000_4000);
      chk("t3_hit_way_a", 32'(hit_way), 32'd2);
      chk("t3_latency_a", 32'(obs_fs - acc_edge), PAR ? 32'd2 : 32'd4);
      access(32'h0000_8000);
      chk("t3_hit_way_b", 32'(hit_way), 32'd2);

      // 4: stack overflow evicts the oldest block
      apply_reset(2);
      for (int k = 0; k <= 16; k++) access(32'h0000_3FF0 + 32'(k) * 32'h4000);
      access(32'h0000_3FF0);
      chk("t4_hit_way", 32'(hit_way), 32'd16);
      chk("t4_msb_index", 32'(msb_index), 32'h3FF);
      chk("t4_latency", 32'(obs_fs - acc_edge), PAR ? 32'd2 : 32'd17);
      chk("t4_miss_count", 32'(l1_miss_count), 32'd18);

      // 5: backpressure with the next request held valid
      start_txn(32'h0000_0010, 1'b1);
      finish_txn(10);
      chk("t5_ready_after_release", 32'(addr_ready), 32'd1);
      start_txn(32'h0000_0010, 1'b0);
      finish_txn(0);
      chk("t5_hit_way", 32'(hit_way), 32'd0);
      chk("t5_hit_count", 32'(l1_hit_count), 32'd1);

      // 6: reset during SEARCH
      access(32'h0000_0020);
      access(32'h0000_4020);
      access(32'h0000_8020);
      start_txn(32'h0000_0020, 1'b0);
      apply_reset(2);
      chk("t6_hit_count", 32'(l1_hit_count), 32'd0);
      chk("t6_miss_count", 32'(l1_miss_count), 32'd0);
      chk("t6_msb_index", 32'(msb_index), 32'd0);
      chk("t6_hit_way", 32'(hit_way), 32'd0);
      repeat (4) @(negedge clk);
      access(32'h0000_8020);
      chk("t6_post_hit_way", 32'(hit_way), 32'd16);
      chk("t6_post_msb_index", 32'(msb_index), 32'd2);
      chk("t6_post_miss_count", 32'(l1_miss_count), 32'd1);

      repeat (3) @(negedge clk);
      #2;
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
